// File: rtl/cpu32_pkg.sv
// Shared CPU32 constants: register file geometry and the hard-wired zero register.
package cpu32_pkg;
    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 16;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'h0;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans i_req upward from i_ptr (wrapping)
// and returns the first set bit as a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);
    logic w_found;
    int   w_pos;

    // NOTE: every output of a combinational block gets a default up front,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_idx          = IDX_W'(w_pos);
                w_found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbitration of writeback sources onto the single register file
// write port, plus the pending-write scoreboard used for RAW stalls at issue.
module regfile_wb_arbiter
    import cpu32_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    input  logic                      flush,
    output logic [ADDR_W-1:0]         addr_w,
    output logic [DATA_W-1:0]         data_w,
    output logic                      write_en,
    output logic [NUM_REGS-1:0]       busy
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]    r_ptr;
    logic [ADDR_W-1:0]   r_addr_w;
    logic [DATA_W-1:0]   r_data_w;
    logic                r_write_en;
    logic [NUM_REGS-1:0] r_busy;

    logic [NUM_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]    w_idx;
    logic                w_accept;
    logic [IDX_W-1:0]    w_ptr_next;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_data;
    logic [NUM_REGS-1:0] w_busy_next;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign req_ready  = w_grant;
    assign w_accept   = |(w_grant & req_valid);
    assign w_win_addr = req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
    assign w_win_data = req_data[int'(w_idx)*DATA_W +: DATA_W];
    assign w_ptr_next = (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_addr_w   <= '0;
            r_data_w   <= '0;
            r_write_en <= 1'b0;
        end else if (w_accept) begin
            r_ptr      <= w_ptr_next;
            r_addr_w   <= w_win_addr;
            r_data_w   <= w_win_data;
            r_write_en <= (w_win_addr != ADDR_W'(REG_ZERO));
        end else begin
            r_write_en <= 1'b0;
        end
    end

    // Commit clears first, then a same-cycle reservation re-sets the bit.
    always_comb begin
        w_busy_next = r_busy;
        if (r_write_en) w_busy_next[r_addr_w] = 1'b0;
        if (rsv_valid && rsv_addr != ADDR_W'(REG_ZERO)) w_busy_next[rsv_addr] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_busy <= '0;
        else if (flush) r_busy <= '0;
        else            r_busy <= w_busy_next;
    end

    assign addr_w   = r_addr_w;
    assign data_w   = r_data_w;
    assign write_en = r_write_en;
    assign busy     = r_busy;
endmodule
